// File: rtl/blob_track_pkg.sv
// Shared types and VGA timing constants for the blob bounding-box tracker.
package blob_track_pkg;

  localparam int H_SYNC_CYC = 96;
  localparam int H_BACK     = 48;
  localparam int H_FRONT    = 16;
  localparam int V_SYNC_CYC = 2;
  localparam int V_BACK     = 33;
  localparam int V_FRONT    = 10;

  // Fields are sized for the largest supported frame; instances narrow them at the ports.
  localparam int COORD_W = 16;
  localparam int COUNT_W = 24;

  typedef struct packed {
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_y;
    logic [COUNT_W-1:0] count;
    logic               overflow;
  } bbox_t;

  localparam bbox_t BBOX_INIT = '{
    min_x: '1, max_x: '0, min_y: '1, max_y: '0, count: '0, overflow: 1'b0
  };

endpackage

// File: rtl/vga_pixel_position.sv
// Recovers the x/y coordinate of the current pixel from blank/vsync timing.
module vga_pixel_position
  import blob_track_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT)
) (
  input  logic          VGA_CLK,
  input  logic          reset_n,
  input  logic          VS,
  input  logic          BLANK_N,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          in_range,
  output logic          line_end,
  output logic          frame_end
);

  localparam logic [XW-1:0] X_LIM = XW'(WIDTH);
  localparam logic [YW-1:0] Y_LIM = YW'(HEIGHT);

  logic prev_vs;
  logic prev_blank;

  assign line_end  = prev_blank & ~BLANK_N;
  assign frame_end = prev_vs & ~VS;
  assign in_range  = (x < X_LIM) && (y < Y_LIM);

  // Counters stick at WIDTH/HEIGHT so oversized lines/frames stay detectable.
  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      x          <= '0;
      y          <= '0;
      prev_vs    <= 1'b0;
      prev_blank <= 1'b0;
    end else begin
      prev_vs    <= VS;
      prev_blank <= BLANK_N;
      if (!VS) begin
        x <= '0;
        y <= '0;
      end else if (line_end) begin
        x <= '0;
        if (y != Y_LIM) y <= y + YW'(1);
      end else if (BLANK_N && (x != X_LIM)) begin
        x <= x + XW'(1);
      end
    end
  end

endmodule

// File: rtl/blob_bbox_tracker.sv
// Per-frame bounding box, pixel count and centre of the thresholded mask,
// published once per frame at the vsync falling edge.
module blob_bbox_tracker
  import blob_track_pkg::*;
#(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = $clog2(WIDTH),
  parameter int YW     = $clog2(HEIGHT),
  parameter int CW     = $clog2(WIDTH*HEIGHT+1)
) (
  input  logic          VGA_CLK,
  input  logic          reset_n,
  input  logic          iVGA_HS,
  input  logic          iVGA_VS,
  input  logic          iVGA_BLANK_N,
  input  logic          iPIXEL_ON,
  output logic [XW-1:0] oMIN_X,
  output logic [XW-1:0] oMAX_X,
  output logic [YW-1:0] oMIN_Y,
  output logic [YW-1:0] oMAX_Y,
  output logic [XW-1:0] oCENTER_X,
  output logic [YW-1:0] oCENTER_Y,
  output logic [CW-1:0] oCOUNT,
  output logic          oFOUND,
  output logic          oOVERFLOW,
  output logic          oFRAME_VALID
);

  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          in_range;
  logic          line_end;
  logic          frame_end;

  vga_pixel_position #(
    .WIDTH (WIDTH),
    .HEIGHT(HEIGHT),
    .XW    (XW),
    .YW    (YW)
  ) u_pos (
    .VGA_CLK  (VGA_CLK),
    .reset_n  (reset_n),
    .VS       (iVGA_VS),
    .BLANK_N  (iVGA_BLANK_N),
    .x        (x),
    .y        (y),
    .in_range (in_range),
    .line_end (line_end),
    .frame_end(frame_end)
  );

  bbox_t               acc;
  bbox_t               res;
  logic                synced;
  logic                frame_valid;
  logic [COORD_W-1:0]  x_ext;
  logic [COORD_W-1:0]  y_ext;
  logic                hit;
  logic                unused_sigs;

  assign x_ext = COORD_W'(x);
  assign y_ext = COORD_W'(y);
  assign hit   = iVGA_BLANK_N && iPIXEL_ON && in_range;

  // HS, line_end and the upper struct bits have no consumer here.
  assign unused_sigs = iVGA_HS ^ line_end ^ (^res);

  always_ff @(posedge VGA_CLK) begin
    if (!reset_n) begin
      acc         <= BBOX_INIT;
      res         <= '0;
      synced      <= 1'b0;
      frame_valid <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      if (frame_end) begin
        acc <= BBOX_INIT;
        if (synced) begin
          frame_valid <= 1'b1;
          res         <= acc;
          // Empty frame: min fields still hold their all-ones seed.
          if (acc.count == '0) begin
            res.min_x <= '0;
            res.min_y <= '0;
          end
        end else begin
          synced <= 1'b1;
        end
      end else begin
        if (iVGA_BLANK_N && !in_range) acc.overflow <= 1'b1;
        if (hit) begin
          acc.count <= acc.count + COUNT_W'(1);
          if (x_ext < acc.min_x) acc.min_x <= x_ext;
          if (x_ext > acc.max_x) acc.max_x <= x_ext;
          if (y_ext < acc.min_y) acc.min_y <= y_ext;
          if (y_ext > acc.max_y) acc.max_y <= y_ext;
        end
      end
    end
  end

  logic [XW:0] sum_x;
  logic [YW:0] sum_y;

  assign oMIN_X       = XW'(res.min_x);
  assign oMAX_X       = XW'(res.max_x);
  assign oMIN_Y       = YW'(res.min_y);
  assign oMAX_Y       = YW'(res.max_y);
  assign sum_x        = {1'b0, oMIN_X} + {1'b0, oMAX_X};
  assign sum_y        = {1'b0, oMIN_Y} + {1'b0, oMAX_Y};
  assign oCENTER_X    = XW'(sum_x >> 1);
  assign oCENTER_Y    = YW'(sum_y >> 1);
  assign oCOUNT       = CW'(res.count);
  assign oFOUND       = (res.count != '0);
  assign oOVERFLOW    = res.overflow;
  assign oFRAME_VALID = frame_valid;

endmodule

// File: tb/tb_blob_bbox_tracker.sv
// Frame-level bench for blob_bbox_tracker on a 10x10 frame with compressed blanking.
module tb_blob_bbox_tracker;

  localparam int W  = 10;
  localparam int H  = 10;
  localparam int XW = $clog2(W);
  localparam int YW = $clog2(H);
  localparam int CW = $clog2(W*H+1);
  localparam int HS_T = 3, HB_T = 2, HF_T = 2;
  localparam int VB_T = 2, VF_T = 1, VS_T = 2;
  localparam int LINE_T = HS_T + HB_T + W + HF_T;
  localparam int MAXL = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic hs = 1'b1, vs = 1'b0, blank_n = 1'b0, pix = 1'b0;
  logic [XW-1:0] min_x, max_x, cen_x;
  logic [YW-1:0] min_y, max_y, cen_y;
  logic [CW-1:0] count;
  logic found, overflow, frame_valid;

  always #20 clk = ~clk;

  blob_bbox_tracker #(.WIDTH(W), .HEIGHT(H)) dut (
    .VGA_CLK     (clk),
    .reset_n     (reset_n),
    .iVGA_HS     (hs),
    .iVGA_VS     (vs),
    .iVGA_BLANK_N(blank_n),
    .iPIXEL_ON   (pix),
    .oMIN_X      (min_x),
    .oMAX_X      (max_x),
    .oMIN_Y      (min_y),
    .oMAX_Y      (max_y),
    .oCENTER_X   (cen_x),
    .oCENTER_Y   (cen_y),
    .oCOUNT      (count),
    .oFOUND      (found),
    .oOVERFLOW   (overflow),
    .oFRAME_VALID(frame_valid)
  );

  typedef struct {
    int min_x, max_x, min_y, max_y, cx, cy, count;
    bit found, ovf;
  } res_t;

  typedef struct {
    int   x0, x1, y0, y1;
    res_t exp;
  } vec_t;

  int   n_checks = 0;
  int   n_pass = 0;
  int   pulses = 0;
  bit   mask [MAXL][MAXL];
  int   line_len [MAXL];
  int   n_lines;
  int   reset_line;
  vec_t vecs [4];

  always @(negedge clk) if (frame_valid === 1'b1) pulses++;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic h, input logic v, input logic b, input logic p);
    @(negedge clk);
    hs = h; vs = v; blank_n = b; pix = p;
  endtask

  task automatic blank_line(input logic v);
    for (int c = 0; c < LINE_T; c++) step(c >= HS_T, v, 1'b0, 1'b0);
  endtask

  function automatic res_t mk(input int a, b, c, d, e, f, g, input bit fo, ov);
    res_t r;
    r.min_x = a; r.max_x = b; r.min_y = c; r.max_y = d;
    r.cx = e; r.cy = f; r.count = g; r.found = fo; r.ovf = ov;
    return r;
  endfunction

  task automatic set_rect(input int x0, x1, y0, y1);
    for (int yy = 0; yy < MAXL; yy++) begin
      line_len[yy] = W;
      for (int xx = 0; xx < MAXL; xx++)
        mask[yy][xx] = (xx >= x0 && xx <= x1 && yy >= y0 && yy <= y1);
    end
    n_lines = H;
    reset_line = -1;
  endtask

  // Reference: scan the drawn frame as a picture and apply the in-range rule directly.
  function automatic res_t model();
    res_t r;
    int mnx = 1 << 30, mxx = -1, mny = 1 << 30, mxy = -1, cnt = 0;
    bit ov = (n_lines > H);
    for (int yy = 0; yy < n_lines; yy++) begin
      if (line_len[yy] > W) ov = 1;
      for (int xx = 0; xx < line_len[yy]; xx++)
        if (xx < W && yy < H && mask[yy][xx]) begin
          cnt++;
          if (xx < mnx) mnx = xx;
          if (xx > mxx) mxx = xx;
          if (yy < mny) mny = yy;
          if (yy > mxy) mxy = yy;
        end
    end
    if (cnt == 0) r = mk(0, 0, 0, 0, 0, 0, 0, 0, ov);
    else r = mk(mnx, mxx, mny, mxy, (mnx + mxx) / 2, (mny + mxy) / 2, cnt, 1, ov);
    return r;
  endfunction

  task automatic check_outputs(input string tag, input res_t e);
    check({tag, ".min_x"}, int'(min_x), e.min_x);
    check({tag, ".max_x"}, int'(max_x), e.max_x);
    check({tag, ".min_y"}, int'(min_y), e.min_y);
    check({tag, ".max_y"}, int'(max_y), e.max_y);
    check({tag, ".center_x"}, int'(cen_x), e.cx);
    check({tag, ".center_y"}, int'(cen_y), e.cy);
    check({tag, ".count"}, int'(count), e.count);
    check({tag, ".found"}, int'(found), int'(e.found));
    check({tag, ".overflow"}, int'(overflow), int'(e.ovf));
  endtask

  // Draws one frame (back porch, active, front porch) and ends it with vsync low.
  task automatic run_frame(input string tag, input bit publish, input res_t e);
    int p0;
    p0 = pulses;
    for (int l = 0; l < VB_T; l++) blank_line(1'b1);
    for (int yy = 0; yy < n_lines; yy++) begin
      if (yy == reset_line) begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          reset_n = 1'b0; hs = 1'b1; vs = 1'b1; blank_n = 1'b0; pix = 1'b0;
        end
        @(negedge clk);
        reset_n = 1'b1;
      end
      for (int c = 0; c < HS_T + HB_T; c++) step(c >= HS_T, 1'b1, 1'b0, 1'b0);
      for (int xx = 0; xx < line_len[yy]; xx++) step(1'b1, 1'b1, 1'b1, mask[yy][xx]);
      for (int c = 0; c < HF_T; c++) step(1'b1, 1'b1, 1'b0, 1'b0);
    end
    for (int l = 0; l < VF_T; l++) blank_line(1'b1);
    for (int c = 0; c < VS_T * LINE_T; c++) begin
      step(c >= HS_T, 1'b0, 1'b0, 1'b0);
      if (c == 1) begin
        check({tag, ".valid"}, int'(frame_valid), int'(publish));
        check_outputs(tag, e);
      end
      if (c == 2) check({tag, ".valid_end"}, int'(frame_valid), 0);
    end
    check({tag, ".pulses"}, pulses - p0, int'(publish));
    $display("frame %s: pulse=%0d count=%0d box=(%0d,%0d)-(%0d,%0d) ovf=%0d",
             tag, pulses - p0, count, min_x, min_y, max_x, max_y, overflow);
  endtask

  initial begin
    res_t zero, e;
    zero = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);

    vecs[0].x0 = 3; vecs[0].x1 = 3; vecs[0].y0 = 4; vecs[0].y1 = 4;
    vecs[0].exp = mk(3, 3, 4, 4, 3, 4, 1, 1, 0);
    vecs[1].x0 = 2; vecs[1].x1 = 5; vecs[1].y0 = 1; vecs[1].y1 = 3;
    vecs[1].exp = mk(2, 5, 1, 3, 3, 2, 12, 1, 0);
    vecs[2].x0 = 1; vecs[2].x1 = 0; vecs[2].y0 = 0; vecs[2].y1 = 0;
    vecs[2].exp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[3].x0 = 0; vecs[3].x1 = 9; vecs[3].y0 = 0; vecs[3].y1 = 9;
    vecs[3].exp = mk(0, 9, 0, 9, 4, 4, 100, 1, 0);

    // Reset held with vsync low; release must not be taken as a frame edge.
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) step(1'b1, 1'b0, 1'b0, 1'b0);
    check_outputs("reset", zero);
    check("reset.valid", int'(frame_valid), 0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 5; c++) step(1'b1, 1'b0, 1'b0, 1'b0);

    set_rect(vecs[0].x0, vecs[0].x1, vecs[0].y0, vecs[0].y1);
    run_frame("discard", 1'b0, zero);

    for (int i = 0; i < 4; i++) begin
      set_rect(vecs[i].x0, vecs[i].x1, vecs[i].y0, vecs[i].y1);
      run_frame($sformatf("vec%0d", i), 1'b1, vecs[i].exp);
    end

    for (int i = 0; i < 6; i++) begin
      int dens;
      set_rect(1, 0, 0, 0);
      dens = $urandom_range(0, 3);
      for (int yy = 0; yy < H; yy++) begin
        if ($urandom_range(0, 5) == 0) line_len[yy] = W + $urandom_range(1, 3);
        for (int xx = 0; xx < line_len[yy]; xx++)
          mask[yy][xx] = (dens != 0) && ($urandom_range(0, 9) < dens);
      end
      e = model();
      run_frame($sformatf("rand%0d", i), 1'b1, e);
    end

    // Oversized line: the pixel at x=11 is dropped but flags overflow.
    set_rect(1, 0, 0, 0);
    mask[6][4] = 1'b1;
    line_len[5] = 12;
    mask[5][11] = 1'b1;
    run_frame("ovf_line", 1'b1, mk(4, 4, 6, 6, 4, 6, 1, 1, 1));
    set_rect(vecs[0].x0, vecs[0].x1, vecs[0].y0, vecs[0].y1);
    run_frame("ovf_clear", 1'b1, vecs[0].exp);

    // Reset mid-frame: that frame is swallowed, the next one publishes normally.
    set_rect(vecs[1].x0, vecs[1].x1, vecs[1].y0, vecs[1].y1);
    reset_line = 5;
    run_frame("rst_mid", 1'b0, zero);
    reset_line = -1;
    run_frame("post_rst", 1'b1, vecs[1].exp);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
